inst_type_decode: RTL

INST_TYPE_DECODE -- requirements
Module: inst_type_decode

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/opcode_classify.sv | 32 +++
 rtl/inst_type_decode.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared decode definitions: opcode constants, skid-buffer state enum, decoded-entry struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    // The entry carries the PC at the widest supported datapath; narrower
    // instances zero-extend on the way in and truncate on the way out.
    localparam int PC_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic R;
        logic I;
        logic L;
        logic S;
        logic B;
        logic J;
        logic Jr;
        logic lui;
        logic aui;
        logic illegal;
    } type_flags_t;

    typedef struct packed {
        type_flags_t       flags;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [PC_W-1:0]   pc;
    } entry_t;

endpackage

// File: rtl/opcode_classify.sv
// Maps a 7-bit major opcode onto one-hot type flags, with illegal for anything unrecognised.
// Latency: purely combinational.
// Backpressure: none; no state.
module opcode_classify
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [9:0] flags
);

    type_flags_t f;

    // Exactly one flag is raised for every opcode value, so the output is always one-hot.
    always_comb begin
        f = '0;
        case (opcode)
            OP_R:    f.R       = 1'b1;
            OP_I:    f.I       = 1'b1;
            OP_L:    f.L       = 1'b1;
            OP_S:    f.S       = 1'b1;
            OP_B:    f.B       = 1'b1;
            OP_J:    f.J       = 1'b1;
            OP_JR:   f.Jr      = 1'b1;
            OP_LUI:  f.lui     = 1'b1;
            OP_AUI:  f.aui     = 1'b1;
            default: f.illegal = 1'b1;
        endcase
    end

    assign flags = f;

endmodule

// File: rtl/inst_type_decode.sv
// Classifies incoming instructions and buffers the decoded entries in a 2-deep skid buffer.
// Latency: 1 cycle from accept to outValid when empty; full rate while outReady is high.
// Backpressure: instReady drops only when both registers are full, from registered state alone.
module inst_type_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instValid,
    output logic            instReady,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] pcIn,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic            R,
    output logic            I,
    output logic            L,
    output logic            S,
    output logic            B,
    output logic            J,
    output logic            Jr,
    output logic            lui,
    output logic            aui,
    output logic            illegal,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] pcOut
);

    buf_state_t  state_q;
    buf_state_t  state_d;
    entry_t      in_ent;
    entry_t      out_q;
    entry_t      skid_q;
    logic [9:0]  in_flags;
    logic        accept;
    logic        pop;
    logic        load_out;
    logic        load_skid;
    logic        move_skid;
    logic        unused_bits;

    opcode_classify u_classify (
        .opcode (inst[6:0]),
        .flags  (in_flags)
    );

    // Fields are taken verbatim for every opcode; consumers ignore what they do not need.
    assign in_ent.flags = in_flags;
    assign in_ent.rd    = inst[11:7];
    assign in_ent.rs1   = inst[19:15];
    assign in_ent.rs2   = inst[24:20];
    assign in_ent.func3 = inst[14:12];
    assign in_ent.func7 = inst[31:25];
    assign in_ent.pc    = PC_W'(pcIn);

    assign instReady = (state_q != TWO);
    assign outValid  = (state_q != EMPTY);

    // A flush cycle neither accepts nor consumes, so nothing offered alongside it survives.
    assign accept = instValid && instReady && !flush;
    assign pop    = outValid && outReady && !flush;

    // State register; reset outranks flush, which is folded into the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and register-load strobes.
    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d  = ONE;
                        load_out = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d   = ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Entry storage: the output register only changes on load or skid promotion, so a stalled entry holds still.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= in_ent;
            end else if (move_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_ent;
            end
        end
    end

    assign R       = out_q.flags.R;
    assign I       = out_q.flags.I;
    assign L       = out_q.flags.L;
    assign S       = out_q.flags.S;
    assign B       = out_q.flags.B;
    assign J       = out_q.flags.J;
    assign Jr      = out_q.flags.Jr;
    assign lui     = out_q.flags.lui;
    assign aui     = out_q.flags.aui;
    assign illegal = out_q.flags.illegal;
    assign rd      = out_q.rd;
    assign rs1     = out_q.rs1;
    assign rs2     = out_q.rs2;
    assign func3   = out_q.func3;
    assign func7   = out_q.func7;
    assign pcOut   = out_q.pc[XLEN-1:0];

    // Upper PC bits beyond XLEN and instruction bits beyond 32 are carried but never observed.
    assign unused_bits = ^{out_q.pc, inst};

endmodule
